// File: rtl/toast_ex_stage_md_pkg.sv
// Shared encodings for the toast execute stage with its iterative multiply/divide unit:
// M-extension funct3 codes, muldiv FSM states, forwarding selects and ALU op codes.
package toast_ex_stage_md_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  localparam logic [1:0] FWD_EX = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b01;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_EQ    = 4'd10;
  localparam logic [3:0] ALU_PASS2 = 4'd11;

  function automatic logic md_is_mul(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic md_a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/toast_ex_stage_md_muldiv.sv
// Iterative RV32M/RV64M unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with the sign fixed up when the result is selected.
module toast_ex_stage_md_muldiv
  import toast_ex_stage_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, mb_q, mb_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d, rneg_q, rneg_d;

  logic              sa_s, sb_s;
  logic [XLEN-1:0]   ma_s, mb_s;
  logic [XLEN:0]     sum_s, shifted_s, diff_s;
  logic [2*XLEN-1:0] prod_s;

  // Operand signs and magnitudes taken at entry
  always_comb begin
    sa_s = md_a_signed(op_i) & a_i[XLEN-1];
    sb_s = md_b_signed(op_i) & b_i[XLEN-1];
    ma_s = sa_s ? -a_i : a_i;
    mb_s = sb_s ? -b_i : b_i;
  end

  // hi:lo is the running product for multiplies and remainder:quotient for divides
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mb_d      = mb_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    sum_s     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : {(XLEN+1){1'b0}});
    shifted_s = {hi_q, lo_q[XLEN-1]};
    diff_s    = shifted_s - {1'b0, mb_q};
    if (flush_i) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            state_d = MD_BUSY;
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = ma_s;
            mb_d    = mb_s;
            op_d    = op_i;
            // a zero divisor must keep the all-ones quotient unsigned-looking
            neg_d   = md_is_mul(op_i) ? (sa_s ^ sb_s) : ((sa_s ^ sb_s) & (b_i != '0));
            rneg_d  = sa_s;
          end else begin
            state_d = MD_IDLE;
          end
        end
        MD_BUSY: begin
          if (md_is_mul(op_q)) begin
            {hi_d, lo_d} = {sum_s, lo_q[XLEN-1:1]};
          end else if (shifted_s >= {1'b0, mb_q}) begin
            hi_d = diff_s[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = shifted_s[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d = MD_DONE;
          end else begin
            state_d = MD_BUSY;
          end
        end
        MD_DONE: begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Sign-corrected result selection
  always_comb begin
    if (neg_q) begin
      prod_s = -{hi_q, lo_q};
    end else begin
      prod_s = {hi_q, lo_q};
    end
    case (op_q)
      MD_MUL:                       result_o = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_o = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result_o = neg_q ? -lo_q : lo_q;
      MD_REM, MD_REMU:              result_o = rneg_q ? -hi_q : hi_q;
      default:                      result_o = '0;
    endcase
  end

  assign busy_o = (state_q == MD_BUSY);
  assign done_o = (state_q == MD_DONE);

  // FSM, counter and shift registers
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mb_q    <= '0;
      op_q    <= 3'b000;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mb_q    <= mb_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
    end
  end

endmodule

// File: rtl/toast_ex_stage_md.sv
// toast execute stage: operand forwarding, ALU, branch resolve and an iterative M unit
// that stalls ID. Define TOAST_FAST_MUL_EN for single-cycle multiplies (divides stay iterative).
module toast_ex_stage_md
  import toast_ex_stage_md_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MEM_OP_W   = 4
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  input  logic                  ID_mem_wr_en_i,
  input  logic                  ID_mem_rd_en_i,
  input  logic                  ID_memtoreg_i,
  input  logic                  ID_rd_wr_en_i,
  input  logic                  ID_jump_en_i,
  input  logic                  ID_branch_flag_i,
  input  logic                  ID_exception_i,
  input  logic                  ID_md_en_i,
  input  logic [MEM_OP_W-1:0]   ID_mem_op_i,
  input  logic [REG_ADDR_W-1:0] ID_rd_addr_i,
  input  logic [REG_ADDR_W-1:0] ID_rs2_addr_i,
  input  logic [1:0]            ID_branch_op_i,
  input  logic [2:0]            ID_md_op_i,
  input  logic [3:0]            ID_alu_ctrl_i,
  input  logic [1:0]            ID_alu_source_sel_i,
  input  logic [1:0]            forwardA_i,
  input  logic [1:0]            forwardB_i,
  input  logic [XLEN-1:0]       ID_pc_i,
  input  logic [XLEN-1:0]       ID_pc_dest_i,
  input  logic [XLEN-1:0]       ID_rs1_data_i,
  input  logic [XLEN-1:0]       ID_rs2_data_i,
  input  logic [XLEN-1:0]       ID_imm1_i,
  input  logic [XLEN-1:0]       ID_imm2_i,
  input  logic [XLEN-1:0]       WB_rd_wr_data_i,
  output logic                  EX_mem_wr_en_o,
  output logic                  EX_mem_rd_en_o,
  output logic                  EX_memtoreg_o,
  output logic                  EX_rd_wr_en_o,
  output logic                  EX_branch_en_o,
  output logic                  EX_exception_o,
  output logic [MEM_OP_W-1:0]   EX_mem_op_o,
  output logic [REG_ADDR_W-1:0] EX_rd_addr_o,
  output logic [REG_ADDR_W-1:0] EX_rs2_addr_o,
  output logic [XLEN-1:0]       EX_alu_result_o,
  output logic [XLEN-1:0]       EX_rs2_data_o,
  output logic [XLEN-1:0]       EX_pc_dest_o
);

  localparam int SH_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONE_C  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] FOUR_C = {{(XLEN-3){1'b0}}, 3'b100};

  logic [XLEN-1:0]       op1_s, op2_s, rs2_fwd_s, alu_s, md_result_s, fast_res_s;
  logic [SH_W-1:0]       shamt_s;
  logic                  md_busy_s, md_done_s, md_legal_s, fast_mul_s, md_start_s, stall_s;
  logic [4:0]            id_ctrl_s, ctrl_q, ctrl_d;
  logic [MEM_OP_W-1:0]   mem_op_q, mem_op_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d, rs2_addr_q, rs2_addr_d;
  logic                  branch_en_q, branch_en_d;
  logic [XLEN-1:0]       alu_q, alu_d, rs2_data_q, rs2_data_d, pc_dest_q, pc_dest_d;
  logic [XLEN-1:0]       rs2_hold_q, rs2_hold_d;
  logic                  unused_pc_s;

  // the PC reaches EX already folded into imm1 by the decoder
  assign unused_pc_s = ^ID_pc_i;

  // Operand selection: jump forms the link address, otherwise forwarding beats rs/imm
  always_comb begin
    case (forwardB_i)
      FWD_EX:  rs2_fwd_s = alu_q;
      FWD_WB:  rs2_fwd_s = WB_rd_wr_data_i;
      default: rs2_fwd_s = ID_rs2_data_i;
    endcase
    if (ID_jump_en_i) begin
      op1_s = ID_imm1_i;
      op2_s = FOUR_C;
    end else begin
      case (forwardA_i)
        FWD_EX:  op1_s = alu_q;
        FWD_WB:  op1_s = WB_rd_wr_data_i;
        default: op1_s = ID_alu_source_sel_i[1] ? ID_imm1_i : ID_rs1_data_i;
      endcase
      case (forwardB_i)
        FWD_EX:  op2_s = alu_q;
        FWD_WB:  op2_s = WB_rd_wr_data_i;
        default: op2_s = ID_alu_source_sel_i[0] ? ID_imm2_i : ID_rs2_data_i;
      endcase
    end
  end

  // ALU
  always_comb begin
    shamt_s = op2_s[SH_W-1:0];
    case (ID_alu_ctrl_i)
      ALU_ADD:   alu_s = op1_s + op2_s;
      ALU_SUB:   alu_s = op1_s - op2_s;
      ALU_SLL:   alu_s = op1_s << shamt_s;
      ALU_SLT:   alu_s = ($signed(op1_s) < $signed(op2_s)) ? ONE_C : '0;
      ALU_SLTU:  alu_s = (op1_s < op2_s) ? ONE_C : '0;
      ALU_XOR:   alu_s = op1_s ^ op2_s;
      ALU_SRL:   alu_s = op1_s >> shamt_s;
      ALU_SRA:   alu_s = $unsigned($signed(op1_s) >>> shamt_s);
      ALU_OR:    alu_s = op1_s | op2_s;
      ALU_AND:   alu_s = op1_s & op2_s;
      ALU_EQ:    alu_s = (op1_s == op2_s) ? ONE_C : '0;
      ALU_PASS2: alu_s = op2_s;
      default:   alu_s = '0;
    endcase
  end

  assign md_legal_s = ID_md_en_i & ~ID_jump_en_i & ~ID_branch_op_i[1];

`ifdef TOAST_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a_s, fast_b_s, fast_prod_s;

  // Single-cycle 2*XLEN product for the multiply group
  always_comb begin
    fast_mul_s  = md_legal_s & md_is_mul(ID_md_op_i);
    fast_a_s    = md_a_signed(ID_md_op_i) ? {{XLEN{op1_s[XLEN-1]}}, op1_s} : {{XLEN{1'b0}}, op1_s};
    fast_b_s    = md_b_signed(ID_md_op_i) ? {{XLEN{op2_s[XLEN-1]}}, op2_s} : {{XLEN{1'b0}}, op2_s};
    fast_prod_s = fast_a_s * fast_b_s;
    if (ID_md_op_i == MD_MUL) begin
      fast_res_s = fast_prod_s[XLEN-1:0];
    end else begin
      fast_res_s = fast_prod_s[2*XLEN-1:XLEN];
    end
  end
`else
  assign fast_mul_s = 1'b0;
  assign fast_res_s = '0;
`endif

  assign md_start_s = resetn_i & ~md_busy_s & ~md_done_s & md_legal_s & ~fast_mul_s & ~flush_i;
  assign stall_s    = resetn_i & (md_start_s | md_busy_s) & ~flush_i;
  assign stall_o    = stall_s;

  toast_ex_stage_md_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .start_i  (md_start_s),
    .flush_i  (flush_i),
    .op_i     (ID_md_op_i),
    .a_i      (op1_s),
    .b_i      (op2_s),
    .busy_o   (md_busy_s),
    .done_o   (md_done_s),
    .result_o (md_result_s)
  );

  assign id_ctrl_s = {ID_mem_wr_en_i, ID_mem_rd_en_i, ID_memtoreg_i, ID_rd_wr_en_i, ID_exception_i};

  // Next EX/MEM contents: flush, M-op completion, bubble, or normal single-cycle op
  always_comb begin
    ctrl_d      = ctrl_q;
    mem_op_d    = mem_op_q;
    rd_addr_d   = rd_addr_q;
    rs2_addr_d  = rs2_addr_q;
    branch_en_d = branch_en_q;
    alu_d       = alu_q;
    rs2_data_d  = rs2_data_q;
    pc_dest_d   = pc_dest_q;
    rs2_hold_d  = rs2_hold_q;
    if (flush_i) begin
      ctrl_d      = '0;
      mem_op_d    = '0;
      rd_addr_d   = '0;
      rs2_addr_d  = '0;
      branch_en_d = 1'b0;
      alu_d       = '0;
      rs2_data_d  = '0;
    end else if (md_done_s) begin
      ctrl_d      = id_ctrl_s;
      mem_op_d    = ID_mem_op_i;
      rd_addr_d   = ID_rd_addr_i;
      rs2_addr_d  = ID_rs2_addr_i;
      branch_en_d = 1'b0;
      alu_d       = md_result_s;
      rs2_data_d  = rs2_hold_q;
      pc_dest_d   = ID_pc_dest_i;
    end else if (stall_s) begin
      ctrl_d      = '0;
      mem_op_d    = '0;
      rd_addr_d   = '0;
      rs2_addr_d  = '0;
      branch_en_d = 1'b0;
      pc_dest_d   = ID_pc_dest_i;
      if (md_start_s) begin
        rs2_hold_d = rs2_fwd_s;
      end else begin
        rs2_hold_d = rs2_hold_q;
      end
    end else begin
      ctrl_d      = id_ctrl_s;
      mem_op_d    = ID_mem_op_i;
      rd_addr_d   = ID_rd_addr_i;
      rs2_addr_d  = ID_rs2_addr_i;
      branch_en_d = ID_branch_op_i[1] & ~ID_jump_en_i & ((alu_s == ONE_C) ^ ID_branch_flag_i);
      alu_d       = fast_mul_s ? fast_res_s : alu_s;
      rs2_data_d  = rs2_fwd_s;
      pc_dest_d   = ID_pc_dest_i;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      ctrl_q      <= '0;
      mem_op_q    <= '0;
      rd_addr_q   <= '0;
      rs2_addr_q  <= '0;
      branch_en_q <= 1'b0;
      alu_q       <= '0;
      rs2_data_q  <= '0;
      pc_dest_q   <= '0;
      rs2_hold_q  <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      mem_op_q    <= mem_op_d;
      rd_addr_q   <= rd_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      branch_en_q <= branch_en_d;
      alu_q       <= alu_d;
      rs2_data_q  <= rs2_data_d;
      pc_dest_q   <= pc_dest_d;
      rs2_hold_q  <= rs2_hold_d;
    end
  end

  assign {EX_mem_wr_en_o, EX_mem_rd_en_o, EX_memtoreg_o, EX_rd_wr_en_o, EX_exception_o} = ctrl_q;
  assign EX_mem_op_o     = mem_op_q;
  assign EX_rd_addr_o    = rd_addr_q;
  assign EX_rs2_addr_o   = rs2_addr_q;
  assign EX_branch_en_o  = branch_en_q;
  assign EX_alu_result_o = alu_q;
  assign EX_rs2_data_o   = rs2_data_q;
  assign EX_pc_dest_o    = pc_dest_q;

endmodule

// File: tb/tb_toast_ex_stage_md.sv
// Directed bench for toast_ex_stage_md: forwarding, branch resolve, iterative M-ops,
// flush mid-divide and asynchronous reset mid-divide.
module tb_toast_ex_stage_md;
  import toast_ex_stage_md_pkg::*;

`ifdef TOAST_FAST_MUL_EN
  localparam int MUL_STALL = 0;
`else
  localparam int MUL_STALL = 33;
`endif
  localparam int DIV_STALL = 33;

  logic        clk_i = 1'b0;
  logic        resetn_i, flush_i, stall_o;
  logic        ID_mem_wr_en_i, ID_mem_rd_en_i, ID_memtoreg_i, ID_rd_wr_en_i;
  logic        ID_jump_en_i, ID_branch_flag_i, ID_exception_i, ID_md_en_i;
  logic [3:0]  ID_mem_op_i;
  logic [4:0]  ID_rd_addr_i, ID_rs2_addr_i;
  logic [1:0]  ID_branch_op_i;
  logic [2:0]  ID_md_op_i;
  logic [3:0]  ID_alu_ctrl_i;
  logic [1:0]  ID_alu_source_sel_i, forwardA_i, forwardB_i;
  logic [31:0] ID_pc_i, ID_pc_dest_i, ID_rs1_data_i, ID_rs2_data_i, ID_imm1_i, ID_imm2_i;
  logic [31:0] WB_rd_wr_data_i;
  logic        EX_mem_wr_en_o, EX_mem_rd_en_o, EX_memtoreg_o, EX_rd_wr_en_o;
  logic        EX_branch_en_o, EX_exception_o;
  logic [3:0]  EX_mem_op_o;
  logic [4:0]  EX_rd_addr_o, EX_rs2_addr_o;
  logic [31:0] EX_alu_result_o, EX_rs2_data_o, EX_pc_dest_o;

  int tests = 0;
  int fails = 0;

  toast_ex_stage_md dut (
    .clk_i(clk_i), .resetn_i(resetn_i), .flush_i(flush_i), .stall_o(stall_o),
    .ID_mem_wr_en_i(ID_mem_wr_en_i), .ID_mem_rd_en_i(ID_mem_rd_en_i),
    .ID_memtoreg_i(ID_memtoreg_i), .ID_rd_wr_en_i(ID_rd_wr_en_i),
    .ID_jump_en_i(ID_jump_en_i), .ID_branch_flag_i(ID_branch_flag_i),
    .ID_exception_i(ID_exception_i), .ID_md_en_i(ID_md_en_i),
    .ID_mem_op_i(ID_mem_op_i), .ID_rd_addr_i(ID_rd_addr_i), .ID_rs2_addr_i(ID_rs2_addr_i),
    .ID_branch_op_i(ID_branch_op_i), .ID_md_op_i(ID_md_op_i), .ID_alu_ctrl_i(ID_alu_ctrl_i),
    .ID_alu_source_sel_i(ID_alu_source_sel_i), .forwardA_i(forwardA_i), .forwardB_i(forwardB_i),
    .ID_pc_i(ID_pc_i), .ID_pc_dest_i(ID_pc_dest_i), .ID_rs1_data_i(ID_rs1_data_i),
    .ID_rs2_data_i(ID_rs2_data_i), .ID_imm1_i(ID_imm1_i), .ID_imm2_i(ID_imm2_i),
    .WB_rd_wr_data_i(WB_rd_wr_data_i),
    .EX_mem_wr_en_o(EX_mem_wr_en_o), .EX_mem_rd_en_o(EX_mem_rd_en_o),
    .EX_memtoreg_o(EX_memtoreg_o), .EX_rd_wr_en_o(EX_rd_wr_en_o),
    .EX_branch_en_o(EX_branch_en_o), .EX_exception_o(EX_exception_o),
    .EX_mem_op_o(EX_mem_op_o), .EX_rd_addr_o(EX_rd_addr_o), .EX_rs2_addr_o(EX_rs2_addr_o),
    .EX_alu_result_o(EX_alu_result_o), .EX_rs2_data_o(EX_rs2_data_o), .EX_pc_dest_o(EX_pc_dest_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic nop();
    {ID_mem_wr_en_i, ID_mem_rd_en_i, ID_memtoreg_i, ID_rd_wr_en_i} = 4'b0000;
    {ID_jump_en_i, ID_branch_flag_i, ID_exception_i, ID_md_en_i} = 4'b0000;
    ID_mem_op_i = 4'd0; ID_rd_addr_i = 5'd0; ID_rs2_addr_i = 5'd0;
    ID_branch_op_i = 2'b00; ID_md_op_i = 3'b000; ID_alu_ctrl_i = ALU_ADD;
    ID_alu_source_sel_i = 2'b00; forwardA_i = 2'b00; forwardB_i = 2'b00;
    ID_pc_i = 32'd0; ID_pc_dest_i = 32'd0; ID_rs1_data_i = 32'd0; ID_rs2_data_i = 32'd0;
    ID_imm1_i = 32'd0; ID_imm2_i = 32'd0; WB_rd_wr_data_i = 32'd0;
  endtask

  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
    int n;
    int bad;
    nop();
    ID_md_en_i = 1'b1; ID_md_op_i = op; ID_rs1_data_i = a; ID_rs2_data_i = b;
    ID_rd_wr_en_i = 1'b1; ID_rd_addr_i = 5'd9;
    #1;
    n = 0;
    bad = 0;
    while (stall_o === 1'b1 && n < 100) begin
      n++;
      step();
      if (EX_rd_wr_en_o !== 1'b0) bad++;
    end
    step();
    chk({tag, "_stall"}, 64'(n), 64'(exp_stall));
    chk({tag, "_bubble"}, 64'(bad), 64'd0);
    chk({tag, "_res"}, {32'd0, EX_alu_result_o}, {32'd0, exp});
    chk({tag, "_rdwr"}, {63'd0, EX_rd_wr_en_o}, 64'd1);
    nop();
  endtask

  initial begin
    resetn_i = 1'b0;
    flush_i  = 1'b0;
    nop();
    #12;
    chk("rst_stall", {63'd0, stall_o}, 64'd0);
    chk("rst_alu", {32'd0, EX_alu_result_o}, 64'd0);
    chk("rst_ctrl", {58'd0, EX_mem_wr_en_o, EX_mem_rd_en_o, EX_memtoreg_o, EX_rd_wr_en_o,
                     EX_branch_en_o, EX_exception_o}, 64'd0);
    chk("rst_pcd", {32'd0, EX_pc_dest_o}, 64'd0);
    step();
    resetn_i = 1'b1;

    // plain ADD 2 + 3
    ID_rs1_data_i = 32'd2; ID_rs2_data_i = 32'd3; ID_rd_wr_en_i = 1'b1; ID_rd_addr_i = 5'd3;
    step();
    chk("add_res", {32'd0, EX_alu_result_o}, 64'd5);
    chk("add_rd", {59'd0, EX_rd_addr_o}, 64'd3);

    // ADD with forwardA from EX: 5 + 7
    forwardA_i = FWD_EX; ID_rs1_data_i = 32'd99; ID_rs2_data_i = 32'd7;
    #1;
    chk("fwdex_stall", {63'd0, stall_o}, 64'd0);
    step();
    chk("fwdex_res", {32'd0, EX_alu_result_o}, 64'd12);
    chk("fwdex_rs2", {32'd0, EX_rs2_data_o}, 64'd7);

    // forwardB from WB: 1 + 100, rs2 data also forwarded
    forwardA_i = 2'b00; ID_rs1_data_i = 32'd1; forwardB_i = FWD_WB;
    WB_rd_wr_data_i = 32'd100; ID_rs2_data_i = 32'd55;
    step();
    chk("fwdwb_res", {32'd0, EX_alu_result_o}, 64'd101);
    chk("fwdwb_rs2", {32'd0, EX_rs2_data_o}, 64'd100);

    // immediates: SUB 0x10 - 3, then SRA 0x80000000 >>> 4
    nop(); ID_rd_wr_en_i = 1'b1;
    ID_alu_source_sel_i = 2'b11; ID_imm1_i = 32'h10; ID_imm2_i = 32'd3; ID_alu_ctrl_i = ALU_SUB;
    step();
    chk("sub_imm", {32'd0, EX_alu_result_o}, 64'hD);
    ID_alu_source_sel_i = 2'b01; ID_rs1_data_i = 32'h8000_0000; ID_imm2_i = 32'd4;
    ID_alu_ctrl_i = ALU_SRA;
    step();
    chk("sra_imm", {32'd0, EX_alu_result_o}, 64'hF800_0000);

    // BEQ taken / flag inverts / JAL link
    nop(); ID_alu_ctrl_i = ALU_EQ; ID_rs1_data_i = 32'd9; ID_rs2_data_i = 32'd9;
    ID_branch_op_i = 2'b10;
    step();
    chk("beq_alu", {32'd0, EX_alu_result_o}, 64'd1);
    chk("beq_taken", {63'd0, EX_branch_en_o}, 64'd1);
    ID_branch_flag_i = 1'b1;
    step();
    chk("beq_flag", {63'd0, EX_branch_en_o}, 64'd0);
    nop(); ID_jump_en_i = 1'b1; ID_branch_op_i = 2'b10; ID_imm1_i = 32'h1000;
    ID_rs1_data_i = 32'd1; ID_rs2_data_i = 32'd1; ID_rd_wr_en_i = 1'b1;
    step();
    chk("jal_link", {32'd0, EX_alu_result_o}, 64'h1004);
    chk("jal_br", {63'd0, EX_branch_en_o}, 64'd0);
    nop();

    // M-ops
    run_md("mul",    MD_MUL,    32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD, MUL_STALL);
    run_md("mulhu",  MD_MULHU,  32'hFFFF_FFFF, 32'd3,         32'h0000_0002, MUL_STALL);
    run_md("mulh",   MD_MULH,   32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, MUL_STALL);
    run_md("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_STALL);
    run_md("mul67",  MD_MUL,    32'd6,         32'd7,         32'd42,        MUL_STALL);
    run_md("divovf", MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_STALL);
    run_md("removf", MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, DIV_STALL);
    run_md("divu0",  MD_DIVU,   32'd7,         32'd0,         32'hFFFF_FFFF, DIV_STALL);
    run_md("remu0",  MD_REMU,   32'd7,         32'd0,         32'd7,         DIV_STALL);
    run_md("divneg", MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_STALL);
    run_md("remneg", MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_STALL);
    run_md("divs0",  MD_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, DIV_STALL);
    run_md("rems0",  MD_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, DIV_STALL);

    // flush at BUSY cycle 10
    ID_md_en_i = 1'b1; ID_md_op_i = MD_DIV; ID_rs1_data_i = 32'd100; ID_rs2_data_i = 32'd7;
    ID_rd_wr_en_i = 1'b1; ID_pc_dest_i = 32'h200;
    #1;
    chk("fl_entry_stall", {63'd0, stall_o}, 64'd1);
    for (int i = 0; i < 11; i++) step();
    chk("fl_busy_stall", {63'd0, stall_o}, 64'd1);
    flush_i = 1'b1; ID_pc_dest_i = 32'h999;
    #1;
    chk("fl_stall_drop", {63'd0, stall_o}, 64'd0);
    step();
    chk("fl_alu", {32'd0, EX_alu_result_o}, 64'd0);
    chk("fl_rs2", {32'd0, EX_rs2_data_o}, 64'd0);
    chk("fl_rdwr", {63'd0, EX_rd_wr_en_o}, 64'd0);
    chk("fl_pcd_hold", {32'd0, EX_pc_dest_o}, 64'h200);
    flush_i = 1'b0;
    nop(); ID_rs1_data_i = 32'd20; ID_rs2_data_i = 32'd22; ID_rd_wr_en_i = 1'b1;
    #1;
    chk("fl_add_stall", {63'd0, stall_o}, 64'd0);
    step();
    chk("fl_add_res", {32'd0, EX_alu_result_o}, 64'd42);

    // async reset in the middle of a divide
    nop(); ID_md_en_i = 1'b1; ID_md_op_i = MD_DIVU; ID_rs1_data_i = 32'd50; ID_rs2_data_i = 32'd5;
    for (int i = 0; i < 6; i++) step();
    chk("rs_busy_stall", {63'd0, stall_o}, 64'd1);
    resetn_i = 1'b0;
    #1;
    chk("rs_stall", {63'd0, stall_o}, 64'd0);
    chk("rs_alu", {32'd0, EX_alu_result_o}, 64'd0);
    chk("rs_pcd", {32'd0, EX_pc_dest_o}, 64'd0);
    nop();
    step();
    resetn_i = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
